// File: rtl/skeleton_param.sv
// Logic-op delay line (d, DEPTH enabled cycles), a->c+->(b&c) sequence detector (e, 1 cycle
// after the completing edge) and saturating hit counter (f); en=0 freezes everything but clr.
module skeleton_param #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    parameter int MODE  = 0,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             e,
    output logic [CNT_W-1:0] f,
    output logic             f_sat
);

    typedef enum logic [1:0] {IDLE, GOT_A, GOT_C, HIT} state_t;

    localparam logic [CNT_W-1:0] F_MAX = '1;

    logic [WIDTH-1:0] op_val;
    logic [WIDTH-1:0] stage [DEPTH];
    state_t           state;
    state_t           state_next;
    logic             sa, sb, sc;
    logic             ev_a, ev_c, ev_bc;
    logic             inc;

    // Unknown MODE values fall back to AND.
    always_comb begin
        op_val = a & b;
        case (MODE)
            1:       op_val = a | b;
            2:       op_val = a ^ b;
            default: op_val = a & b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else if (en) begin
            stage[0] <= op_val;
            for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
    end

    assign d = stage[DEPTH-1];

    assign sa    = |a;
    assign sb    = |b;
    assign sc    = |c;
    assign ev_a  = sa & ~sb & ~sc;
    assign ev_c  = sc & ~sa & ~sb;
    assign ev_bc = sb & sc & ~sa;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_next;
        end
    end

    // HIT behaves like IDLE so back-to-back sequences each produce a pulse.
    always_comb begin
        state_next = IDLE;
        e          = 1'b0;
        case (state)
            GOT_A: begin
                if (ev_c)      state_next = GOT_C;
                else if (ev_a) state_next = GOT_A;
            end
            GOT_C: begin
                if (ev_bc)     state_next = HIT;
                else if (ev_c) state_next = GOT_C;
                else if (ev_a) state_next = GOT_A;
            end
            HIT: begin
                e = 1'b1;
                if (ev_a)      state_next = GOT_A;
            end
            default: begin
                if (ev_a)      state_next = GOT_A;
            end
        endcase
    end

    assign inc = en & (state_next == HIT);

    // clr wins over a simultaneous hit; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f <= '0;
        end else if (clr) begin
            f <= '0;
        end else if (inc && (f != F_MAX)) begin
            f <= f + CNT_W'(1);
        end
    end

    assign f_sat = (f == F_MAX);

endmodule
